// File: rtl/rbroute_pkg.sv
// rbroute_pkg -- shared definitions for the register-space router.
//   NSPACE      : number of decoded register spaces (width of the one-hot bus)
//   space_e     : symbolic index of each space, bit 0 upward
//   SPACE_BASE  : first register index of each space
//   SPACE_SIZE  : number of register indices in each space
//   MAP_LIMIT   : first index that is never mapped
`ifndef RB_SPACE_W
`define RB_SPACE_W (rbroute_pkg::NSPACE)
`endif

package rbroute_pkg;

  localparam int NSPACE = 18;

  typedef enum logic [4:0] {
    SP_D0, SP_D1, SP_A0, SP_A1, SP_B0, SP_B1, SP_P, SP_M, SP_U0, SP_U1,
    SP_DC, SP_PC, SP_BM, SP_BMS, SP_LP, SP_LC, SP_FC, SP_EP
  } space_e;

  localparam int SPACE_BASE [NSPACE] = '{
    'h00, 'h10, 'h20, 'h28, 'h30, 'h38, 'h40, 'h50, 'h60, 'h64,
    'h68, 'h69, 'h6A, 'h6B, 'h6C, 'h6D, 'h6E, 'h6F
  };

  localparam int SPACE_SIZE [NSPACE] = '{
    16, 16, 8, 8, 8, 8, 16, 16, 4, 4,
    1, 1, 1, 1, 1, 1, 1, 1
  };

  localparam int MAP_LIMIT = 'h70;

endpackage

// File: rtl/rbroute_decode.sv
// rbdecode -- combinational register-space decoder.
//   idx_i   : register index
//   space_o : one-hot space select, all-zero when the index is unmapped
//   off_o   : index minus the base of the selected space, 0 when unmapped
//   err_o   : index maps to no space
module rbdecode
  import rbroute_pkg::*;
#(
  parameter int IDXW = 7
) (
  input  logic [IDXW-1:0]   idx_i,
  output logic [NSPACE-1:0] space_o,
  output logic [IDXW-1:0]   off_o,
  output logic              err_o
);

  logic [IDXW-1:0] off_term [NSPACE];

  // Every space lies below MAP_LIMIT, so indices at or above it (including
  // all upper codes of wider indices) simply hit nothing.
  for (genvar gi = 0; gi < NSPACE; gi++) begin : g_space
    localparam logic [IDXW-1:0] BASE = IDXW'(SPACE_BASE[gi]);
    localparam logic [IDXW-1:0] LIM  = IDXW'(SPACE_BASE[gi] + SPACE_SIZE[gi]);
    assign space_o[gi]  = (idx_i >= BASE) && (idx_i < LIM);
    assign off_term[gi] = space_o[gi] ? (idx_i - BASE) : '0;
  end

  // Spaces are disjoint, so at most one term is non-zero.
  always_comb begin
    off_o = '0;
    for (int i = 0; i < NSPACE; i++) begin
      off_o = off_o | off_term[i];
    end
  end

  assign err_o = ~|space_o;

endmodule

// File: rtl/rbroute.sv
// rbroute -- round-robin register-request router with space decode.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : per-port request handshake
//   in_idx/in_we/in_wdata : per-port request fields (flattened, port 0 in LSBs)
//   out_valid/out_ready   : output register handshake
//   out_space/out_off/out_err : decoded space of the accepted request
//   out_port/out_we/out_wdata : source port and forwarded write fields
//   err_cnt           : saturating count of accepted unmapped requests
module rbroute
  import rbroute_pkg::*;
#(
  parameter  int NPORT = 2,
  parameter  int IDXW  = 7,
  parameter  int DW    = 32,
  localparam int PW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NPORT-1:0]      in_valid,
  output logic [NPORT-1:0]      in_ready,
  input  logic [NPORT*IDXW-1:0] in_idx,
  input  logic [NPORT-1:0]      in_we,
  input  logic [NPORT*DW-1:0]   in_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NSPACE-1:0]     out_space,
  output logic [IDXW-1:0]       out_off,
  output logic [PW-1:0]         out_port,
  output logic                  out_we,
  output logic [DW-1:0]         out_wdata,
  output logic                  out_err,
  output logic [15:0]           err_cnt
);

  logic [IDXW-1:0] idx_arr   [NPORT];
  logic [DW-1:0]   wdata_arr [NPORT];

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_unpack
    assign idx_arr[gi]   = in_idx[gi*IDXW +: IDXW];
    assign wdata_arr[gi] = in_wdata[gi*DW +: DW];
  end

  logic              out_valid_q, out_valid_d;
  logic [NSPACE-1:0] out_space_q, out_space_d;
  logic [IDXW-1:0]   out_off_q,   out_off_d;
  logic [PW-1:0]     out_port_q,  out_port_d;
  logic              out_we_q,    out_we_d;
  logic [DW-1:0]     out_wdata_q, out_wdata_d;
  logic              out_err_q,   out_err_d;
  logic [15:0]       err_cnt_q,   err_cnt_d;
  logic [PW-1:0]     ptr_q,       ptr_d;

  // Arbiter: first valid port at or after the pointer, wrapping.
  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  int            cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NPORT; i++) begin
      cand = (int'(ptr_q) + i) % NPORT;
      if (!gnt_found && in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(cand);
      end
    end
  end

  logic loadable;
  logic load;

  assign loadable = !out_valid_q || out_ready;
  assign load     = loadable && gnt_found;

  // Gated by rst_n so nothing is accepted while the design is held in reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && load) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  logic [NSPACE-1:0] dec_space;
  logic [IDXW-1:0]   dec_off;
  logic              dec_err;

  rbdecode #(.IDXW(IDXW)) u_dec (
    .idx_i   (idx_arr[gnt_idx]),
    .space_o (dec_space),
    .off_o   (dec_off),
    .err_o   (dec_err)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_space_d = out_space_q;
    out_off_d   = out_off_q;
    out_port_d  = out_port_q;
    out_we_d    = out_we_q;
    out_wdata_d = out_wdata_q;
    out_err_d   = out_err_q;
    if (loadable) begin
      // Drains to empty when nothing is granted; payload fields just hold.
      out_valid_d = gnt_found;
      if (gnt_found) begin
        out_space_d = dec_space;
        out_off_d   = dec_off;
        out_port_d  = gnt_idx;
        out_we_d    = in_we[gnt_idx];
        out_wdata_d = wdata_arr[gnt_idx];
        out_err_d   = dec_err;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = (gnt_idx == PW'(NPORT - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (load && dec_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_space_q <= '0;
      out_off_q   <= '0;
      out_port_q  <= '0;
      out_we_q    <= 1'b0;
      out_wdata_q <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_space_q <= out_space_d;
      out_off_q   <= out_off_d;
      out_port_q  <= out_port_d;
      out_we_q    <= out_we_d;
      out_wdata_q <= out_wdata_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_space = out_space_q;
  assign out_off   = out_off_q;
  assign out_port  = out_port_q;
  assign out_we    = out_we_q;
  assign out_wdata = out_wdata_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rbroute.sv
module tb_rbroute;

  localparam int NP = 2;
  localparam int IW = 7;
  localparam int W  = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NP-1:0]  in_valid = '0;
  logic [NP-1:0]  in_ready;
  logic [NP*IW-1:0] in_idx = '0;
  logic [NP-1:0]  in_we = '0;
  logic [NP*W-1:0] in_wdata = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [17:0]    out_space;
  logic [IW-1:0]  out_off;
  logic [0:0]     out_port;
  logic           out_we;
  logic [W-1:0]   out_wdata;
  logic           out_err;
  logic [15:0]    err_cnt;

  rbroute #(.NPORT(NP), .IDXW(IW), .DW(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .in_we(in_we), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_space(out_space), .out_off(out_off), .out_port(out_port),
    .out_we(out_we), .out_wdata(out_wdata), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the output register contents.
  bit          m_ov;
  logic [17:0] m_space;
  int          m_off;
  int          m_port;
  bit          m_we;
  logic [31:0] m_wdata;
  bit          m_err;
  int          m_cnt;
  int          m_ptr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Address map from the block-size layout: two 16-blocks, four 8-blocks,
  // two 16-blocks, two 4-blocks, then eight singles, then unmapped.
  function automatic void ref_map(input int idx, output logic [17:0] sp,
                                  output int off, output bit err);
    int b;
    sp = '0; off = 0; err = 1'b0; b = 0;
    if (idx >= 'h70) begin
      err = 1'b1;
    end else begin
      if (idx < 'h20)      begin b = idx / 16;                off = idx % 16; end
      else if (idx < 'h40) begin b = 2 + (idx - 'h20) / 8;    off = idx % 8;  end
      else if (idx < 'h60) begin b = 6 + (idx - 'h40) / 16;   off = idx % 16; end
      else if (idx < 'h68) begin b = 8 + (idx - 'h60) / 4;    off = idx % 4;  end
      else                 begin b = 10 + (idx - 'h68);       off = 0;        end
      sp[b] = 1'b1;
    end
  endfunction

  task automatic set_port(input int p, input bit v, input int idx, input bit we,
                          input logic [31:0] wd);
    in_valid[p]        = v;
    in_idx[p*IW +: IW] = IW'(idx);
    in_we[p]           = we;
    in_wdata[p*W +: W] = wd;
  endtask

  // One clock: check in_ready against the model, clock, update model, check outputs.
  task automatic tick();
    bit         loadable;
    int         g;
    logic [1:0] exp_rdy;
    #1;
    loadable = !m_ov || out_ready;
    g = -1;
    for (int i = 0; i < NP; i++) begin
      int p;
      p = (m_ptr + i) % NP;
      if (g < 0 && in_valid[p]) g = p;
    end
    exp_rdy = (loadable && g >= 0) ? (2'b01 << g) : 2'b00;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (loadable) begin
      if (g >= 0) begin
        m_ov    = 1'b1;
        m_port  = g;
        m_we    = in_we[g];
        m_wdata = in_wdata[g*W +: W];
        ref_map(int'(in_idx[g*IW +: IW]), m_space, m_off, m_err);
        if (m_err && m_cnt != 'hFFFF) m_cnt++;
        m_ptr = (g + 1) % NP;
      end else begin
        m_ov = 1'b0;
      end
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
    if (m_ov) begin
      chk("out_space", 64'(out_space), 64'(m_space));
      chk("out_off", 64'(out_off), 64'(m_off));
      chk("out_port", 64'(out_port), 64'(m_port));
      chk("out_we", 64'(out_we), 64'(m_we));
      chk("out_wdata", 64'(out_wdata), 64'(m_wdata));
      chk("out_err", 64'(out_err), 64'(m_err));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    m_ov = 1'b0; m_cnt = 0; m_ptr = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          idx;
    bit          we;
    logic [31:0] wdata;
    logic [17:0] sp;
    int          off;
    bit          err;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [31:0] held;
    vt[0]  = '{'h00, 1, 32'h1,        18'h00001, 0,  0};
    vt[1]  = '{'h0F, 0, 32'h2,        18'h00001, 15, 0};
    vt[2]  = '{'h10, 1, 32'h3,        18'h00002, 0,  0};
    vt[3]  = '{'h27, 0, 32'h4,        18'h00004, 7,  0};
    vt[4]  = '{'h3C, 1, 32'h5,        18'h00020, 4,  0};
    vt[5]  = '{'h5F, 0, 32'h6,        18'h00080, 15, 0};
    vt[6]  = '{'h63, 1, 32'h7,        18'h00100, 3,  0};
    vt[7]  = '{'h64, 0, 32'h8,        18'h00200, 0,  0};
    vt[8]  = '{'h68, 1, 32'h9,        18'h00400, 0,  0};
    vt[9]  = '{'h6F, 0, 32'hA,        18'h20000, 0,  0};
    vt[10] = '{'h70, 1, 32'hB,        18'h00000, 0,  1};
    vt[11] = '{'h7F, 0, 32'hDEADBEEF, 18'h00000, 0,  1};

    do_reset();

    // Alternating grants from a fresh pointer.
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1, 'h10 + i, 0, 32'h100 + i);
      set_port(1, 1, 'h40 + i, 1, 32'h200 + i);
      tick();
      chk("alt_port", 64'(out_port), 64'(i % 2));
      chk("alt_valid", 64'(out_valid), 64'd1);
    end

    // Single write on port 0.
    set_port(1, 0, 0, 0, 0);
    set_port(0, 1, 'h2A, 1, 32'h1234);
    tick();
    chk("w_space", 64'(out_space), 64'h8);
    chk("w_off", 64'(out_off), 64'h2);
    chk("w_port", 64'(out_port), 64'd0);
    chk("w_we", 64'(out_we), 64'd1);
    chk("w_wdata", 64'(out_wdata), 64'h1234);
    chk("w_err", 64'(out_err), 64'd0);

    // Map boundaries, table-driven.
    for (int i = 0; i < 12; i++) begin
      set_port(0, 1, vt[i].idx, vt[i].we, vt[i].wdata);
      tick();
      chk("tbl_space", 64'(out_space), 64'(vt[i].sp));
      chk("tbl_off", 64'(out_off), 64'(vt[i].off));
      chk("tbl_err", 64'(out_err), 64'(vt[i].err));
      chk("tbl_wdata", 64'(out_wdata), 64'(vt[i].wdata));
      set_port(0, 0, 0, 0, 0);
      tick();
    end

    // Backpressure: hold three cycles, then drain.
    set_port(0, 1, 'h30, 1, 32'hAAAA0000);
    set_port(1, 1, 'h50, 0, 32'hBBBB0000);
    tick();
    held = m_wdata;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_port(0, 1, 'h31 + i, 1, 32'hAAAA0001 + i);
      set_port(1, 1, 'h51 + i, 0, 32'hBBBB0001 + i);
      tick();
      chk("bp_rdy", 64'(in_ready), 64'd0);
      chk("bp_hold", 64'(out_wdata), 64'(held));
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_drain", 64'(out_wdata == held), 64'd0);
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    tick();

    // Unmapped then last single.
    do_reset();
    set_port(0, 1, 'h75, 0, 32'h0);
    tick();
    chk("e_err", 64'(out_err), 64'd1);
    chk("e_space", 64'(out_space), 64'd0);
    chk("e_cnt", 64'(err_cnt), 64'd1);
    set_port(0, 1, 'h6F, 0, 32'h0);
    tick();
    chk("ep_space", 64'(out_space), 64'h20000);
    chk("ep_off", 64'(out_off), 64'd0);
    chk("ep_cnt", 64'(err_cnt), 64'd1);

    // Full sweep.
    do_reset();
    for (int i = 0; i < 128; i++) begin
      set_port(0, 1, i, i[0], 32'(i * 7));
      tick();
    end
    chk("sweep_cnt", 64'(err_cnt), 64'd16);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NP; p++) begin
        set_port(p, bit'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
                 bit'($urandom_range(0, 1)), $urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Reset mid-stream with a held request.
    out_ready = 1'b0;
    set_port(0, 1, 'h70, 0, 32'h5);
    set_port(1, 1, 'h71, 0, 32'h6);
    tick();
    tick();
    chk("mr_pre_valid", 64'(out_valid), 64'd1);
    do_reset();
    out_ready = 1'b1;
    tick();
    chk("mr_first_port", 64'(out_port), 64'd0);
    chk("mr_cnt", 64'(err_cnt), 64'd1);
    tick();
    chk("mr_second_port", 64'(out_port), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rbroute.md
RBROUTE -- requirements
Module: rbroute

Interface
REQ-001 Parameter NPORT, default 2: number of requester ports; legal range 1..8.
REQ-002 Parameter IDXW, default 7: register index width; legal range 7..10.
REQ-003 Parameter DW, default 32: write data width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  NPORT  per-port request valid.
REQ-007 in_ready  output  NPORT  per-port request accepted this cycle.
REQ-008 in_idx  input  NPORT x IDXW  per-port register index.
REQ-009 in_we  input  NPORT  per-port write flag.
REQ-010 in_wdata  input  NPORT x DW  per-port write data.
REQ-011 out_valid  output  1  decoded request held in the output register.
REQ-012 out_ready  input  1  downstream accepts the output.
REQ-013 out_space  output  NSPACE (18)  one-hot register space; all-zero when unmapped.
REQ-014 out_off  output  IDXW  index minus the base of the selected space; 0 when unmapped.
REQ-015 out_port, out_we, out_wdata  output  clog2(NPORT) (min 1), 1, DW  source port and forwarded write fields.
REQ-016 out_err  output  1  index maps to no space.
REQ-017 err_cnt  output  16  saturating count of accepted unmapped requests.

Function
REQ-018 The space map SHALL be, bit 0 upward: 0x00-0F, 0x10-1F, 0x20-27, 0x28-2F, 0x30-37, 0x38-3F, 0x40-4F, 0x50-5F, 0x60-63, 0x64-67, 0x68, 0x69, 0x6A, 0x6B, 0x6C, 0x6D, 0x6E, 0x6F (d, d, a, a, b, b, p, m, u, u, dc, pc, bm, bms, lp, lc, fc, ep).
REQ-019 Every index >= 0x70, including all upper codes when IDXW > 7, SHALL be unmapped.
REQ-020 Round-robin arbitration: the grant goes to the first valid port at or after the priority pointer, wrapping modulo NPORT.
REQ-021 The output register is loadable when out_valid=0 or out_ready=1 (load = that condition AND a granted valid request).
REQ-022 in_ready SHALL be high only for the granted port and only when the output register is loadable; in_ready is combinational from in_valid, out_valid and out_ready.
REQ-023 Latency: a request accepted in cycle N SHALL appear at the output with out_valid=1 in cycle N+1.
REQ-024 Full throughput: one request per cycle when out_ready stays high.
REQ-025 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable and every in_ready SHALL be 0.
REQ-026 Acceptance of port k SHALL set the priority pointer to (k+1) mod NPORT; with no acceptance the pointer holds.
REQ-027 If out_ready=1 and there is no valid request, out_valid SHALL drop to 0 on the next edge.
REQ-028 On accepting an unmapped request: out_err=1, out_space=0, out_off=0, and err_cnt increments (saturating at 0xFFFF).
REQ-029 A mapped request SHALL set exactly one out_space bit.
REQ-030 With NPORT=1, arbitration SHALL degenerate to pass-through and out_port SHALL be constant 0.

Reset
REQ-031 rst_n low SHALL asynchronously clear out_valid, out_err, out_space, out_off, out_port, out_we, out_wdata, err_cnt and the priority pointer (pointer = port 0).
REQ-032 in_ready SHALL be 0 while rst_n is low.
REQ-033 A request held in the output register when reset asserts SHALL be discarded.
REQ-034 The first acceptance is allowed on the first rising edge after rst_n deasserts.

Structure
REQ-035 A shared package SHALL hold the NSPACE constant, the space-index enumeration and the base/size table; the existing per-space width macro SHALL derive from NSPACE.
REQ-036 A combinational sub-module rbdecode (index in -> one-hot space, offset, err out) SHALL implement the map, instanced once after the arbiter mux.
REQ-037 Arbiter, output register and error counter SHALL reside in rbroute.

Verification
REQ-038 Port 0: idx 0x2A, we=1, wdata 0x1234, out_ready=1 -> next cycle out_space bit 3, out_off 0x02, out_port 0, out_we=1, out_wdata 0x1234, out_err=0.
REQ-039 Ports 0 and 1 continuously valid, out_ready=1 -> grants alternate 0,1,0,1, one output per cycle.
REQ-040 out_ready held low for 3 cycles with out_valid=1 -> out_* stable for those 3 cycles and in_ready=0; the held request drains on the cycle out_ready rises.
REQ-041 idx 0x75, then idx 0x6F -> out_err=1 with out_space=0 and err_cnt=1; then out_space bit 17, out_off 0 and err_cnt stays 1.
REQ-042 Sweep idx 0x00..0x7F -> the out_space bit and out_off match REQ-018 for every index, and err_cnt=16 at the end.
REQ-043 rst_n pulsed low mid-stream with out_valid=1 -> out_valid=0 immediately, pointer=0, err_cnt=0; the first grant after reset goes to port 0.
